pulse_gen: RTL and testbench
============================

# pulse_gen

Cycle-based periodic pulse generator: after a programmable start delay it drives a rectangular waveform of fixed width and period, plus its complement. It is the synthesizable counterpart of the behavioural `pulse` clock source used by the link clocking models. All times are integer counts of `clk` cycles. It is the base waveform source from which the jittered clock outputs are derived.

## Interface
- `TD`, 0: start delay in cycles; integer ≥ 0.
- `TW`, 2: pulse width in cycles; integer ≥ 0.
- `TP`, 4: period in cycles; integer ≥ 1.
- `B0`, 1'b0: idle/initial level of `out`; the active level is `~B0`.
- `CNT_W`, derived: counter width = `$clog2(max(TD,TP)+1)`, minimum 1; not user-set.
- `clk`  input  1  sole clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `en`  input  1  count enable; when low, all state and outputs hold.
- `out`  output  1  registered pulse waveform.
- `outb`  output  1  registered complement of `out`, always `~out`.

## Operation
- Two internal states:
  - DELAY: delay counter counts `TD` enabled cycles.
  - RUN: phase counter runs 0..TP-1 and wraps to 0.
- Reset, with `rst` sampled high on an edge:
  - `out`=B0 and `outb`=~B0.
  - State = DELAY, or RUN with phase 0 when `TD`=0.
  - All counters = 0.
- Let n = number of enabled edges (`en`=1, `rst`=0) since reset release, with the first such edge as n=1. After edge n:
  - `out` = ~B0 iff (n-1) ≥ TD and ((n-1-TD) mod TP) < TW.
  - Otherwise `out` = B0.
- `out` is decoded from the next-state counter values and registered; no combinational path from inputs to outputs.
- `en`=0: counters, state, `out` and `outb` all hold; the waveform resumes exactly where it stopped.
- `rst` has priority over `en`.
- Reset mid-operation restarts the whole sequence, including the `TD` delay, on the next enabled edge.
- Boundary rules:
  - `TW`=0: `out` stays B0 permanently.
  - `TW` ≥ `TP`: `out` stays ~B0 permanently once the delay expires.
  - `TP`=1 with `TW`=1: constant ~B0 after the delay.
  - Phase counter wrap: TP-1 -> 0 on the next enabled edge with no skipped or doubled cycle.
  - Delay counter saturates at `TD`; no wrap.
- Parameter checks at elaboration:
  - `TP` < 1 is a fatal error.
  - Negative `TD` or `TW` is a fatal error.

## Timing
- Output latency: one edge. `out` reflects counter state n at edge n.
- First active edge after reset release: edge TD+1.
- High (active) time per period: exactly min(TW,TP) enabled cycles.
- Idle time per period: TP-min(TW,TP) enabled cycles.
- Period: TP enabled cycles exactly, every period, with no drift.
- `out` and `outb` change on the same edge; they are never equal.
- Reset values take effect on the edge `rst` is sampled high, not asynchronously.

## Test plan
- Default params (TD=0, TW=2, TP=4, B0=0), `en`=1, release reset: `out` after edges 1..8 = 1,1,0,0,1,1,0,0. `outb` is its inverse on every edge.
- TD=3, TW=1, TP=3, B0=1: edges 1..3 `out`=1; edges 4..9 = 0,1,1,0,1,1.
- Enable gating with defaults: drop `en` after edge 1 for 5 cycles. `out` holds 1 throughout the gap, then continues 1,0,0,1…, so the phase is preserved.
- Reset mid-run, TD=2, TW=2, TP=4: assert `rst` for one edge while `out`=1. `out` becomes 0 on that edge, stays 0 for 2 enabled edges, then rises on the 3rd.
- Degenerate widths, TP=4, TD=0: with TW=0, `out`=0 for 20 edges; with TW=5, `out`=1 on every edge from edge 1.
- Long run, TD=0, TW=3, TP=7: over 700 enabled edges, count exactly 100 rising transitions and 300 active cycles, with every rising edge spaced 7 cycles apart.

Source files
------------

// File: rtl/pulse_gen_if.sv
// Pulse generator control/waveform bundle.
// Master drives the enable; slave returns the waveform pair.
interface pulse_gen_if;
    logic en;
    logic out;
    logic outb;

    modport master (output en, input out, input outb);
    modport slave  (input en, output out, output outb);
endinterface

// File: rtl/pulse_gen.sv
// Periodic pulse generator: start delay, then fixed width/period
// waveform on out with its registered complement on outb.
module pulse_gen #(
    parameter int   TD = 0,
    parameter int   TW = 2,
    parameter int   TP = 4,
    parameter logic B0 = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    pulse_gen_if.slave  pg
);

    localparam int MAXV  = (TD > TP) ? TD : TP;
    localparam int CNT_W = (MAXV < 1) ? 1 : $clog2(MAXV + 1);
    localparam int TWC   = (TW < 0) ? 0 : ((TW > TP) ? TP : TW);

    localparam logic [CNT_W-1:0] TD_C    = CNT_W'(TD);
    localparam logic [CNT_W-1:0] TW_C    = CNT_W'(TWC);
    localparam logic [CNT_W-1:0] TP_LAST = CNT_W'(TP - 1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic {
        S_DELAY,
        S_RUN
    } state_t;

    localparam state_t S_INIT = (TD == 0) ? S_RUN : S_DELAY;

    if (TP < 1) begin : g_bad_tp
        $fatal(1, "pulse_gen: TP must be >= 1");
    end
    if (TD < 0) begin : g_bad_td
        $fatal(1, "pulse_gen: TD must be >= 0");
    end
    if (TW < 0) begin : g_bad_tw
        $fatal(1, "pulse_gen: TW must be >= 0");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_dcnt;
    logic [CNT_W-1:0] w_dcnt_nxt;
    logic [CNT_W-1:0] r_pcnt;
    logic [CNT_W-1:0] w_pcnt_nxt;
    logic             r_out;
    logic             r_outb;
    logic             w_active;
    logic             w_out_nxt;

    // r_pcnt is the phase of the edge about to be taken
    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_pcnt_nxt  = r_pcnt;
        w_active    = 1'b0;
        unique case (r_state)
            S_DELAY: begin
                if (r_dcnt != TD_C) begin
                    w_dcnt_nxt = r_dcnt + ONE;
                end
                if (r_dcnt + ONE == TD_C) begin
                    w_state_nxt = S_RUN;
                    w_pcnt_nxt  = '0;
                end
            end
            S_RUN: begin
                w_active   = (r_pcnt < TW_C);
                w_pcnt_nxt = (r_pcnt == TP_LAST) ? '0 : r_pcnt + ONE;
            end
            default: begin
                w_state_nxt = S_INIT;
            end
        endcase
        w_out_nxt = w_active ? ~B0 : B0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_INIT;
            r_dcnt  <= '0;
            r_pcnt  <= '0;
            r_out   <= B0;
            r_outb  <= ~B0;
        end else if (pg.en) begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_pcnt  <= w_pcnt_nxt;
            r_out   <= w_out_nxt;
            r_outb  <= ~w_out_nxt;
        end
    end

    assign pg.out  = r_out;
    assign pg.outb = r_outb;

endmodule

// File: tb/tb_pulse_gen.sv
// Bench for pulse_gen: six parameterisations driven in lockstep,
// hand-written vectors plus a formula model feeding a scoreboard.
module tb_pulse_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    always #5 clk = ~clk;

    pulse_gen_if if0 ();
    pulse_gen_if if1 ();
    pulse_gen_if if2 ();
    pulse_gen_if if3 ();
    pulse_gen_if if4 ();
    pulse_gen_if if5 ();

    assign if0.en = en;
    assign if1.en = en;
    assign if2.en = en;
    assign if3.en = en;
    assign if4.en = en;
    assign if5.en = en;

    pulse_gen #(.TD(0), .TW(2), .TP(4), .B0(1'b0)) u0 (.clk(clk), .rst(rst), .pg(if0));
    pulse_gen #(.TD(3), .TW(1), .TP(3), .B0(1'b1)) u1 (.clk(clk), .rst(rst), .pg(if1));
    pulse_gen #(.TD(2), .TW(2), .TP(4), .B0(1'b0)) u2 (.clk(clk), .rst(rst), .pg(if2));
    pulse_gen #(.TD(0), .TW(0), .TP(4), .B0(1'b0)) u3 (.clk(clk), .rst(rst), .pg(if3));
    pulse_gen #(.TD(0), .TW(5), .TP(4), .B0(1'b0)) u4 (.clk(clk), .rst(rst), .pg(if4));
    pulse_gen #(.TD(0), .TW(3), .TP(7), .B0(1'b0)) u5 (.clk(clk), .rst(rst), .pg(if5));

    logic [5:0] w_o;
    logic [5:0] w_ob;
    assign w_o  = {if5.out,  if4.out,  if3.out,  if2.out,  if1.out,  if0.out};
    assign w_ob = {if5.outb, if4.outb, if3.outb, if2.outb, if1.outb, if0.outb};

    int   tda [6] = '{0, 3, 2, 0, 0, 0};
    int   twa [6] = '{2, 1, 2, 0, 5, 3};
    int   tpa [6] = '{4, 3, 4, 4, 4, 7};
    logic b0a [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    typedef struct {
        logic       r;
        logic       e;
        logic [2:0] x;
    } vec_t;

    typedef struct {
        logic [5:0] o;
        logic [2:0] h;
        logic       hv;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];
    int   n_mod = 0;
    int   vecs  = 0;
    int   errs  = 0;

    function automatic logic exp_out(input int n, input int k);
        if (n >= 1 && (n - 1) >= tda[k] &&
            ((n - 1 - tda[k]) % tpa[k]) < twa[k])
            return ~b0a[k];
        return b0a[k];
    endfunction

    function automatic void add(input logic r, input logic e,
                                input logic x0, input logic x1,
                                input logic x2);
        vec_t v;
        v.r = r;
        v.e = e;
        v.x = {x2, x1, x0};
        tbl.push_back(v);
    endfunction

    task automatic check();
        sb_t s;
        if (sbq.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL scoreboard_empty got=0 need=1");
            return;
        end
        s = sbq.pop_front();
        for (int k = 0; k < 6; k++) begin
            vecs++;
            if (w_o[k] !== s.o[k]) begin
                errs++;
                $display("FAIL out[u%0d] n=%0d got=%b need=%b",
                         k, n_mod, w_o[k], s.o[k]);
            end
            vecs++;
            if (w_ob[k] !== ~s.o[k]) begin
                errs++;
                $display("FAIL outb[u%0d] n=%0d got=%b need=%b",
                         k, n_mod, w_ob[k], ~s.o[k]);
            end
        end
        if (s.hv) begin
            for (int k = 0; k < 3; k++) begin
                vecs++;
                if (w_o[k] !== s.h[k]) begin
                    errs++;
                    $display("FAIL table[u%0d] n=%0d got=%b need=%b",
                             k, n_mod, w_o[k], s.h[k]);
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic e,
                        input logic hv, input logic [2:0] h);
        sb_t s;
        rst = r;
        en  = e;
        if (r)
            n_mod = 0;
        else if (e)
            n_mod++;
        for (int k = 0; k < 6; k++)
            s.o[k] = exp_out(n_mod, k);
        s.h  = h;
        s.hv = hv;
        sbq.push_back(s);
        @(posedge clk);
        #1;
        check();
    endtask

    int rises;
    int active;
    int gap_err;
    int last_rise;
    int u3_ones;
    logic prev5;

    initial begin
        // columns: rst, en, u0, u1, u2
        add(1, 1, 0, 1, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 0, 0, 1);
        add(0, 1, 0, 1, 1);
        // enable gap after the first edge
        add(1, 1, 0, 1, 0);
        add(0, 1, 1, 1, 0);
        for (int i = 0; i < 5; i++)
            add(0, 0, 1, 1, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1);
        add(0, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 0, 0, 1);
        // reset while u2 is active
        add(1, 1, 0, 1, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 1, 1, 0);
        add(0, 1, 0, 1, 1);
        // reset wins over a low enable
        add(1, 0, 0, 1, 0);
        add(0, 1, 1, 1, 0);

        repeat (2) @(posedge clk);
        #1;
        foreach (tbl[i])
            step(tbl[i].r, tbl[i].e, 1'b1, tbl[i].x);

        for (int i = 0; i < 150; i++)
            step(($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 3) != 0), 1'b0, 3'b000);

        step(1'b1, 1'b1, 1'b0, 3'b000);
        prev5     = if5.out;
        rises     = 0;
        active    = 0;
        gap_err   = 0;
        last_rise = -1;
        u3_ones   = 0;
        for (int i = 1; i <= 700; i++) begin
            step(1'b0, 1'b1, 1'b0, 3'b000);
            if (if5.out === 1'b1)
                active++;
            if (if3.out !== 1'b0)
                u3_ones++;
            if (prev5 === 1'b0 && if5.out === 1'b1) begin
                if (last_rise >= 0 && (i - last_rise) != 7)
                    gap_err++;
                last_rise = i;
                rises++;
            end
            prev5 = if5.out;
        end

        vecs++;
        if (rises != 100) begin
            errs++;
            $display("FAIL long_rises got=%0d need=100", rises);
        end
        vecs++;
        if (active != 300) begin
            errs++;
            $display("FAIL long_active got=%0d need=300", active);
        end
        vecs++;
        if (gap_err != 0) begin
            errs++;
            $display("FAIL long_spacing got=%0d need=0", gap_err);
        end
        vecs++;
        if (u3_ones != 0) begin
            errs++;
            $display("FAIL tw0_ones got=%0d need=0", u3_ones);
        end
        vecs++;
        if (sbq.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_left got=%0d need=0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
